// File: rtl/coef_pkg.sv
// Shared types and constants for the coefficient loader front end.
package coef_pkg;

    localparam int DEFAULT_WORD_W  = 32;
    localparam int BYTES_PER_FRAME = 2 * DEFAULT_WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        PEND  = 2'd3
    } coef_state_t;

    typedef logic signed [DEFAULT_WORD_W-1:0] coef_t;

    // Number of data bytes carried by one frame (two little-endian words).
    function automatic int frame_bytes(input int word_w);
        return 2 * word_w / 8;
    endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-stage synchroniser for a bus of asynchronous pins, with a rising-edge
// detector on one selected bit. All bits share the same chain so they stay aligned.
module pin_sync #(
    parameter int W        = 10,
    parameter int STAGES   = 2,
    parameter int EDGE_BIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         rise
);

    logic edge_prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [W-1:0] q_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (ena) begin
                        q_reg <= d;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (ena) begin
                        q_reg <= g_stage[gi-1].q_reg;
                    end
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_prev_reg <= 1'b0;
        end else if (ena) begin
            edge_prev_reg <= q[EDGE_BIT];
        end
    end

    // A frozen design must not see an edge, so the detector is gated by ena.
    assign rise = ena & q[EDGE_BIT] & ~edge_prev_reg;

endmodule

// File: rtl/coef_loader.sv
// Deserialises two signed coefficient words from a strobed byte interface and
// hands them to the eigen core with a start pulse. COEF_LOADER_CKSUM_EN adds an XOR checksum byte.
module coef_loader
    import coef_pkg::*;
#(
    parameter int WORD_W      = DEFAULT_WORD_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [7:0]               in_byte,
    input  logic                     in_strobe,
    input  logic                     in_sof,
    input  logic                     core_busy,
    output logic signed [WORD_W-1:0] a0,
    output logic signed [WORD_W-1:0] a1,
    output logic                     start_calc,
    output logic                     loader_busy,
    output logic                     frame_err
);

    localparam int WB    = WORD_W / 8;
    localparam int BYTES = frame_bytes(WORD_W);
    localparam int IW    = $clog2(BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

    logic [9:0]  pins_q;
    logic        byte_evt;
    logic [7:0]  byte_sync;
    logic        sof_sync;
    logic        strobe_sync_unused;

    coef_state_t               state_reg;
    logic [IW-1:0]             cnt_reg;
    logic [BYTES-1:0][7:0]     shadow_reg;
`ifdef COEF_LOADER_CKSUM_EN
    logic [7:0]                xor_reg;
`endif

    pin_sync #(
        .W        (10),
        .STAGES   (SYNC_STAGES),
        .EDGE_BIT (8)
    ) u_pin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .d     ({in_sof, in_strobe, in_byte}),
        .q     (pins_q),
        .rise  (byte_evt)
    );

    assign byte_sync          = pins_q[7:0];
    assign strobe_sync_unused = pins_q[8];
    assign sof_sync           = pins_q[9];
    assign loader_busy        = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            a0         <= '0;
            a1         <= '0;
            start_calc <= 1'b0;
            frame_err  <= 1'b0;
`ifdef COEF_LOADER_CKSUM_EN
            xor_reg    <= '0;
`endif
        end else if (!ena) begin
            start_calc <= 1'b0;
        end else begin
            start_calc <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (byte_evt) begin
                        if (sof_sync) begin
                            shadow_reg[0] <= byte_sync;
                            cnt_reg       <= IW'(1);
                            frame_err     <= 1'b0;
                            state_reg     <= LOAD;
`ifdef COEF_LOADER_CKSUM_EN
                            xor_reg       <= byte_sync;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    if (byte_evt) begin
                        if (sof_sync) begin
                            // Resync: a new SOF restarts the frame without flagging an error.
                            shadow_reg[0] <= byte_sync;
                            cnt_reg       <= IW'(1);
`ifdef COEF_LOADER_CKSUM_EN
                            xor_reg       <= byte_sync;
`endif
                        end else begin
                            shadow_reg[cnt_reg] <= byte_sync;
                            cnt_reg             <= cnt_reg + 1'b1;
`ifdef COEF_LOADER_CKSUM_EN
                            xor_reg             <= xor_reg ^ byte_sync;
                            if (cnt_reg == LAST_IDX) begin
                                state_reg <= CHECK;
                            end
`else
                            if (cnt_reg == LAST_IDX) begin
                                state_reg <= PEND;
                            end
`endif
                        end
                    end
                end

`ifdef COEF_LOADER_CKSUM_EN
                CHECK: begin
                    if (byte_evt) begin
                        if (sof_sync) begin
                            shadow_reg[0] <= byte_sync;
                            cnt_reg       <= IW'(1);
                            xor_reg       <= byte_sync;
                            state_reg     <= LOAD;
                        end else if (byte_sync == xor_reg) begin
                            state_reg <= PEND;
                        end else begin
                            frame_err  <= 1'b1;
                            shadow_reg <= '0;
                            cnt_reg    <= '0;
                            state_reg  <= IDLE;
                        end
                    end
                end
`endif

                PEND: begin
                    // Bytes arriving before the core accepts the frame are overruns.
                    if (byte_evt) begin
                        frame_err <= 1'b1;
                    end
                    if (!core_busy) begin
                        a0         <= shadow_reg[WB-1:0];
                        a1         <= shadow_reg[BYTES-1:WB];
                        start_calc <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_loader.sv
// Directed testbench for coef_loader: frame load, busy hold, resync, errors, reset, enable.
module tb_coef_loader;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic [7:0]         in_byte;
    logic               in_strobe;
    logic               in_sof;
    logic               core_busy;
    logic signed [31:0] a0;
    logic signed [31:0] a1;
    logic               start_calc;
    logic               loader_busy;
    logic               frame_err;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    coef_loader #(
        .WORD_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_byte     (in_byte),
        .in_strobe   (in_strobe),
        .in_sof      (in_sof),
        .core_busy   (core_busy),
        .a0          (a0),
        .a1          (a1),
        .start_calc  (start_calc),
        .loader_busy (loader_busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_calc === 1'b1) pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] fbyte(input logic [31:0] x0, input logic [31:0] x1, input int i);
        logic [63:0] w;
        w = {x1, x0};
        return w[8*i +: 8];
    endfunction

    // Final byte on the wire: the top a1 byte, or the XOR checksum when enabled.
    function automatic logic [7:0] last_byte(input logic [31:0] x0, input logic [31:0] x1);
`ifdef COEF_LOADER_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 8; i++) x = x ^ fbyte(x0, x1, i);
        return x;
`else
        return fbyte(x0, x1, 7);
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic sof);
        in_byte = b;
        in_sof  = sof;
        @(negedge clk);
        in_strobe = 1'b1;
        repeat (5) @(negedge clk);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_head(input logic [31:0] x0, input logic [31:0] x1);
        send_byte(fbyte(x0, x1, 0), 1'b1);
        for (int i = 1; i < 7; i++) send_byte(fbyte(x0, x1, i), 1'b0);
`ifdef COEF_LOADER_CKSUM_EN
        send_byte(fbyte(x0, x1, 7), 1'b0);
`endif
    endtask

    task automatic send_frame(input logic [31:0] x0, input logic [31:0] x1);
        send_head(x0, x1);
        send_byte(last_byte(x0, x1), 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_byte   = 8'h00;
        in_strobe = 1'b0;
        in_sof    = 1'b0;
        core_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a0", a0, 32'h0);
        check("rst_a1", a1, 32'h0);
        check("rst_start", {31'b0, start_calc}, 32'h0);
        check("rst_busy", {31'b0, loader_busy}, 32'h0);
        check("rst_err", {31'b0, frame_err}, 32'h0);

        // Basic frame with exact start_calc latency on the last byte.
        send_head(32'h12345678, 32'hFFFFFFFE);
        in_byte = last_byte(32'h12345678, 32'hFFFFFFFE);
        in_sof  = 1'b0;
        @(negedge clk);
        in_strobe = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_before", {31'b0, start_calc}, 32'h0);
        check("lat_pend_busy", {31'b0, loader_busy}, 32'h1);
        @(negedge clk);
        check("lat_pulse", {31'b0, start_calc}, 32'h1);
        check("basic_a0", a0, 32'h12345678);
        check("basic_a1", a1, 32'hFFFFFFFE);
        @(negedge clk);
        check("lat_after", {31'b0, start_calc}, 32'h0);
        in_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("basic_err", {31'b0, frame_err}, 32'h0);
        check("basic_idle", {31'b0, loader_busy}, 32'h0);
        check("basic_pulses", pulses, 32'd1);

        // Busy hold: frame waits in PEND while core_busy is high.
        core_busy = 1'b1;
        send_frame(32'h11223344, 32'h00000005);
        repeat (20) @(negedge clk);
        check("hold_busy", {31'b0, loader_busy}, 32'h1);
        check("hold_pulses", pulses, 32'd1);
        check("hold_a0", a0, 32'h12345678);
        check("hold_a1", a1, 32'hFFFFFFFE);
        core_busy = 1'b0;
        @(negedge clk);
        check("hold_release_pulse", {31'b0, start_calc}, 32'h1);
        check("hold_new_a0", a0, 32'h11223344);
        check("hold_new_a1", a1, 32'h00000005);
        @(negedge clk);
        check("hold_release_single", {31'b0, start_calc}, 32'h0);

        // Resync: a partial frame is abandoned by a fresh SOF.
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_frame(32'h00000001, 32'h00000002);
        repeat (3) @(negedge clk);
        check("resync_a0", a0, 32'h00000001);
        check("resync_a1", a1, 32'h00000002);
        check("resync_err", {31'b0, frame_err}, 32'h0);
        check("resync_pulses", pulses, 32'd3);

        // Errors: stray byte in IDLE, overrun in PEND, cleared by the next SOF.
        send_byte(8'h55, 1'b0);
        check("stray_err", {31'b0, frame_err}, 32'h1);
        check("stray_idle", {31'b0, loader_busy}, 32'h0);
        core_busy = 1'b1;
        send_frame(32'hCAFEF00D, 32'h00000BAD);
        check("sof_clears_err", {31'b0, frame_err}, 32'h0);
        send_byte(8'h77, 1'b0);
        check("overrun_err", {31'b0, frame_err}, 32'h1);
        check("overrun_busy", {31'b0, loader_busy}, 32'h1);
        core_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("overrun_a0", a0, 32'hCAFEF00D);
        check("overrun_a1", a1, 32'h00000BAD);
        check("overrun_pulses", pulses, 32'd4);
        send_frame(32'h00000003, 32'h00000004);
        repeat (3) @(negedge clk);
        check("err_cleared", {31'b0, frame_err}, 32'h0);
        check("err_frame_a0", a0, 32'h00000003);

        // Reset in the middle of a frame.
        send_byte(8'h11, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b0);
        check("mid_busy", {31'b0, loader_busy}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_a0", a0, 32'h0);
        check("mid_rst_a1", a1, 32'h0);
        check("mid_rst_busy", {31'b0, loader_busy}, 32'h0);
        check("mid_rst_err", {31'b0, frame_err}, 32'h0);

        // ena=0 mid-frame: a strobe during the freeze is lost, frame then completes.
        send_byte(fbyte(32'h89ABCDEF, 32'h76543210, 0), 1'b1);
        send_byte(fbyte(32'h89ABCDEF, 32'h76543210, 1), 1'b0);
        send_byte(fbyte(32'h89ABCDEF, 32'h76543210, 2), 1'b0);
        ena = 1'b0;
        @(negedge clk);
        send_byte(8'h99, 1'b0);
        check("ena_hold_busy", {31'b0, loader_busy}, 32'h1);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 3; i < 7; i++) send_byte(fbyte(32'h89ABCDEF, 32'h76543210, i), 1'b0);
`ifdef COEF_LOADER_CKSUM_EN
        send_byte(fbyte(32'h89ABCDEF, 32'h76543210, 7), 1'b0);
`endif
        check("ena_no_early_pulse", pulses, 32'd5);
        send_byte(last_byte(32'h89ABCDEF, 32'h76543210), 1'b0);
        repeat (3) @(negedge clk);
        check("ena_a0", a0, 32'h89ABCDEF);
        check("ena_a1", a1, 32'h76543210);
        check("ena_pulses", pulses, 32'd6);
        check("ena_err", {31'b0, frame_err}, 32'h0);

`ifdef COEF_LOADER_CKSUM_EN
        // Checksum: 78^56^34^12^D0^00^00^00 = D8 accepted, a wrong byte rejected.
        send_head(32'h12345678, 32'h000000D0);
        send_byte(8'hD8, 1'b0);
        repeat (3) @(negedge clk);
        check("ck_good_a0", a0, 32'h12345678);
        check("ck_good_a1", a1, 32'h000000D0);
        check("ck_good_pulses", pulses, 32'd7);
        check("ck_good_err", {31'b0, frame_err}, 32'h0);
        send_head(32'hDEADBEEF, 32'h00000001);
        send_byte(8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("ck_bad_err", {31'b0, frame_err}, 32'h1);
        check("ck_bad_idle", {31'b0, loader_busy}, 32'h0);
        check("ck_bad_pulses", pulses, 32'd7);
        check("ck_bad_a0", a0, 32'h12345678);
        check("ck_bad_a1", a1, 32'h000000D0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
